// File: rtl/mips_cpu_instr_queue_if.sv
// Handshake and decode-field bundle between instruction memory, the
// instruction queue and the control/decode logic.
interface mips_cpu_instr_queue_if #(
  parameter int DEPTH    = 4,
  parameter int PC_WIDTH = 32,
  parameter int CNT_W    = $clog2(DEPTH + 1)
);
  logic [31:0]         mem_input;
  logic [PC_WIDTH-1:0] mem_pc;
  logic                mem_valid;
  logic                mem_ready;
  logic                flush;
  logic                out_ready;
  logic                out_valid;
  logic [5:0]          op;
  logic [4:0]          rs;
  logic [4:0]          rt;
  logic [4:0]          rd;
  logic [4:0]          shift;
  logic [5:0]          func;
  logic [15:0]         i;
  logic [25:0]         mem_address;
  logic [PC_WIDTH-1:0] instr_pc;
  logic [CNT_W-1:0]    count;

  modport master (
    output mem_input, mem_pc, mem_valid, flush, out_ready,
    input  mem_ready, out_valid, op, rs, rt, rd, shift, func, i,
           mem_address, instr_pc, count
  );

  modport slave (
    input  mem_input, mem_pc, mem_valid, flush, out_ready,
    output mem_ready, out_valid, op, rs, rt, rd, shift, func, i,
           mem_address, instr_pc, count
  );
endinterface

// File: rtl/mips_cpu_instr_queue.sv
// Circular instruction FIFO with PC tags, zero-latency bypass when empty,
// flush on branch/jump, and the head word pre-split into MIPS decode fields.
module mips_cpu_instr_queue #(
  parameter int DEPTH    = 4,
  parameter int PC_WIDTH = 32,
  parameter int CNT_W    = $clog2(DEPTH + 1)
) (
  input logic                    clk,
  input logic                    reset,
  mips_cpu_instr_queue_if.slave  q
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [31:0]         word_mem [DEPTH];
  logic [PC_WIDTH-1:0] pc_mem   [DEPTH];
  logic [PTR_W-1:0]    wp, rp;
  logic [CNT_W-1:0]    count;

  logic                empty, full, bypass, head_valid;
  logic                push, pop, do_write, do_read;
  logic [31:0]         head_word;
  logic [PC_WIDTH-1:0] head_pc;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_comb begin
    empty      = (count == '0);
    full       = (count == CNT_W'(DEPTH));
    bypass     = empty && q.mem_valid && !q.flush && !reset;
    head_valid = (!empty && !q.flush && !reset) || bypass;
    push       = q.mem_valid && q.mem_ready;
    pop        = head_valid && q.out_ready;
    // A bypassed word taken straight away never touches storage; a bypassed
    // word left waiting is written like any other push.
    do_write   = push && !(bypass && q.out_ready);
    do_read    = pop && !bypass;
  end

  always_comb begin
    head_word = '0;
    head_pc   = '0;
    if (head_valid) begin
      head_word = empty ? q.mem_input : word_mem[rp];
      head_pc   = empty ? q.mem_pc    : pc_mem[rp];
    end
  end

  assign q.mem_ready   = !reset && !q.flush && !full;
  assign q.out_valid   = head_valid;
  assign q.op          = head_word[31:26];
  assign q.rs          = head_word[25:21];
  assign q.rt          = head_word[20:16];
  assign q.rd          = head_word[15:11];
  assign q.shift       = head_word[10:6];
  assign q.func        = head_word[5:0];
  assign q.i           = head_word[15:0];
  assign q.mem_address = head_word[25:0];
  assign q.instr_pc    = head_pc;
  assign q.count       = count;

  // Control state: pointers and occupancy
  always_ff @(posedge clk) begin
    if (reset || q.flush) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (do_write) wp <= next_ptr(wp);
      if (do_read)  rp <= next_ptr(rp);
      case ({do_write, do_read})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage is never reset; mem_ready already excludes reset and flush cycles
  always_ff @(posedge clk) begin
    if (do_write) begin
      word_mem[wp] <= q.mem_input;
      pc_mem[wp]   <= q.mem_pc;
    end
  end
endmodule

// File: tb/tb_mips_cpu_instr_queue.sv
// Self-checking bench: directed scenarios plus random traffic against a
// queue-based reference model of the instruction queue.
module tb_mips_cpu_instr_queue;
  localparam int DEPTH = 4;
  localparam int PW    = 32;
  localparam int CW    = $clog2(DEPTH + 1);

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_errors = 0;

  logic [31:0] mw_q[$];
  logic [PW-1:0] pc_q[$];

  always #5 clk = ~clk;

  mips_cpu_instr_queue_if #(.DEPTH(DEPTH), .PC_WIDTH(PW), .CNT_W(CW)) bus ();

  mips_cpu_instr_queue #(.DEPTH(DEPTH), .PC_WIDTH(PW), .CNT_W(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .q     (bus.slave)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic mv, input logic [31:0] w,
                       input logic [PW-1:0] pc, input logic fl, input logic ordy);
    @(negedge clk);
    reset         = rst;
    bus.mem_valid = mv;
    bus.mem_input = w;
    bus.mem_pc    = pc;
    bus.flush     = fl;
    bus.out_ready = ordy;
    #1;
  endtask

  task automatic check_model();
    logic          ev, er;
    logic [31:0]   ew;
    logic [PW-1:0] ep;
    int            n;
    n  = mw_q.size();
    er = !reset && !bus.flush && (n < DEPTH);
    ev = 1'b0;
    ew = '0;
    ep = '0;
    if (!reset && !bus.flush) begin
      if (n > 0) begin
        ev = 1'b1; ew = mw_q[0]; ep = pc_q[0];
      end else if (bus.mem_valid) begin
        ev = 1'b1; ew = bus.mem_input; ep = bus.mem_pc;
      end
    end
    check("out_valid", bus.out_valid, ev);
    check("mem_ready", bus.mem_ready, er);
    check("fields", {bus.op, bus.rs, bus.rt, bus.rd, bus.shift, bus.func}, ew);
    check("imm", bus.i, ew[15:0]);
    check("mem_address", bus.mem_address, ew[25:0]);
    check("instr_pc", bus.instr_pc, ep);
    check("count", bus.count, n);
  endtask

  task automatic tick();
    int   n;
    logic bp, pop, push;
    @(posedge clk);
    if (reset || bus.flush) begin
      mw_q.delete();
      pc_q.delete();
    end else begin
      n    = mw_q.size();
      bp   = (n == 0) && bus.mem_valid;
      pop  = (n > 0 || bus.mem_valid) && bus.out_ready;
      push = bus.mem_valid && (n < DEPTH);
      if (!(bp && bus.out_ready)) begin
        if (pop && n > 0) begin
          void'(mw_q.pop_front());
          void'(pc_q.pop_front());
        end
        if (push) begin
          mw_q.push_back(bus.mem_input);
          pc_q.push_back(bus.mem_pc);
        end
      end
    end
  endtask

  task automatic step(input logic rst, input logic mv, input logic [31:0] w,
                      input logic [PW-1:0] pc, input logic fl, input logic ordy);
    drive(rst, mv, w, pc, fl, ordy);
    check_model();
    tick();
  endtask

  initial begin
    // Initial reset, unchecked because count is unknown beforehand
    drive(1'b1, 1'b0, '0, '0, 1'b0, 1'b0);
    tick();

    // Reset then idle
    drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
    check("rst_count", bus.count, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_fields", {bus.op, bus.rs, bus.rt, bus.rd, bus.shift, bus.func, bus.i, bus.mem_address}, 0);
    check("rst_instr_pc", bus.instr_pc, 0);
    check("rst_mem_ready", bus.mem_ready, 1);
    check_model();
    tick();

    // Bypass: add $8,$9,$10 consumed directly
    drive(1'b0, 1'b1, 32'h012A4020, 32'h100, 1'b0, 1'b1);
    check("byp_valid", bus.out_valid, 1);
    check("byp_op", bus.op, 0);
    check("byp_rs", bus.rs, 9);
    check("byp_rt", bus.rt, 10);
    check("byp_rd", bus.rd, 8);
    check("byp_func", bus.func, 32'h20);
    check("byp_pc", bus.instr_pc, 32'h100);
    check_model();
    tick();
    drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
    check("byp_count", bus.count, 0);
    check_model();
    tick();

    // Fill to DEPTH with out_ready low
    for (int k = 0; k < 5; k++) begin
      drive(1'b0, 1'b1, 32'h20080001 + k, PW'(4 * k), 1'b0, 1'b0);
      if (k == 4) begin
        check("fill_count", bus.count, 4);
        check("fill_ready", bus.mem_ready, 0);
        check("fill_head", {bus.op, bus.rs, bus.rt, bus.rd, bus.shift, bus.func}, 32'h20080001);
        check("fill_imm", bus.i, 1);
        check("fill_pc", bus.instr_pc, 0);
      end
      check_model();
      tick();
    end

    // Drop to 3, then simultaneous push/pop through a pointer wrap
    step(1'b0, 1'b0, '0, '0, 1'b0, 1'b1);
    for (int k = 0; k < 10; k++) begin
      drive(1'b0, 1'b1, 32'h24000000 + k, PW'(32'h200 + 4 * k), 1'b0, 1'b1);
      check("wrap_count", bus.count, 3);
      check_model();
      tick();
    end

    // Flush with traffic present
    drive(1'b0, 1'b1, 32'hDEADBEEF, 32'h300, 1'b1, 1'b1);
    check("fl_ready", bus.mem_ready, 0);
    check("fl_valid", bus.out_valid, 0);
    check_model();
    tick();
    drive(1'b0, 1'b1, 32'h08000010, 32'h400, 1'b0, 1'b0);
    check("fl_count", bus.count, 0);
    check("fl_byp_addr", bus.mem_address, 26'h0000010);
    check_model();
    tick();
    drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
    check("fl_head_addr", bus.mem_address, 26'h0000010);
    check("fl_head_pc", bus.instr_pc, 32'h400);
    check_model();
    tick();

    // Reset mid-operation with count = 2
    step(1'b0, 1'b1, 32'h8C000001, 32'h404, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 32'h8C000002, 32'h408, 1'b0, 1'b0);
    check("rm_count_before", bus.count, 2);
    check_model();
    tick();
    drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
    check("rm_count", bus.count, 0);
    check("rm_valid", bus.out_valid, 0);
    check_model();
    tick();

    // Random traffic
    for (int k = 0; k < 2000; k++) begin
      step($urandom_range(0, 99) == 0, $urandom_range(0, 9) < 7, $urandom,
           PW'($urandom), $urandom_range(0, 19) == 0, $urandom_range(0, 1) == 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
